// File: rtl/mp_add_seq.sv
// mp_add_seq: sequential multi-precision add/subtract controller wrapped
// around an external WIDTH-bit adder. Operand limbs stream in LSB-first on a
// valid/ready interface; result limbs stream out registered, with carry,
// signed-overflow and zero flags valid on the final limb.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          operand limb handshake
//   in_a, in_b                 operand limbs
//   in_first, in_last          limb is least/most significant of an operation
//   in_sub                     A-B when set (sampled on the first limb)
//   add_a, add_b, add_cin      combinational drive to the adder
//   add_sum, add_cout          adder results
//   out_valid/out_ready        result limb handshake
//   out_sum, out_last          result limb and final-limb marker
//   out_carry, out_ovf, out_zero  operation flags, meaningful when out_last=1
module mp_add_seq #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_sub,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  logic carry_q;
  logic sub_q;
  logic zero_acc;

  logic accept;
  logic sub_eff;
  logic zero_nxt;
  logic carry_into_msb;

  // Single output register: a limb can enter whenever the slot is free or
  // being drained in the same cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A first limb restarts the chain from the port, ignoring any stale state.
  assign sub_eff = in_first ? in_sub : sub_q;
  assign add_a   = in_a;
  assign add_b   = sub_eff ? ~in_b : in_b;
  assign add_cin = in_first ? in_sub : carry_q;

  assign zero_nxt       = (in_first || zero_acc) && (add_sum == '0);
  assign carry_into_msb = add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_sum[WIDTH-1];

  // Inter-limb chain state; cleared after the final limb of an operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      zero_acc <= 1'b1;
    end else if (accept) begin
      if (in_first) begin
        sub_q <= in_sub;
      end
      if (in_last) begin
        carry_q  <= 1'b0;
        zero_acc <= 1'b1;
      end else begin
        carry_q  <= add_cout;
        zero_acc <= zero_nxt;
      end
    end
  end

  // Result register; flags only update on the final limb and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sum   <= add_sum;
      out_last  <= in_last;
      if (in_last) begin
        out_carry <= add_cout;
        out_ovf   <= carry_into_msb ^ add_cout;
        out_zero  <= zero_nxt;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Sequential multi-precision add/subtract controller placed directly around the 64-bit Sklansky adder datapath.
- Accepts a stream of 64-bit operand limbs (LSB limb first) on a valid/ready interface and drives the adder's a, b and cin inputs.
- Captures the adder's sum and cout, and chains the carry/borrow across limbs.
- Presents registered result limbs with status flags on a valid/ready output interface.

Parameters:
- WIDTH, 64, limb width; must equal the adder width (multiple of 16).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand limb valid
- in_ready  output  1  block can accept a limb this cycle
- in_a  input  WIDTH  operand A limb
- in_b  input  WIDTH  operand B limb
- in_first  input  1  limb is the least-significant limb of an operation
- in_last  input  1  limb is the most-significant limb of an operation
- in_sub  input  1  operation is A-B; sampled on the first limb, held for the whole operation
- add_a  output  WIDTH  to adder a
- add_b  output  WIDTH  to adder b
- add_cin  output  1  to adder cin
- add_sum  input  WIDTH  from adder sum
- add_cout  input  1  from adder cout
- out_valid  output  1  result limb valid
- out_ready  input  1  consumer accepts the result limb
- out_sum  output  WIDTH  result limb
- out_last  output  1  result limb is the final limb
- out_carry  output  1  carry out (add) or NOT borrow (sub); meaningful when out_last=1
- out_ovf  output  1  signed overflow of the full-width result; meaningful when out_last=1
- out_zero  output  1  all limbs of the operation are zero; meaningful when out_last=1

Behaviour:
- Reset (async, rst_n=0): carry_q=0, sub_q=0, zero_acc=1, out_valid=0, out_sum=0, out_last=0, out_carry=0, out_ovf=0, out_zero=0.
- Adder drive is combinational from the input port:
  - add_a=in_a.
  - add_b = in_sub_eff ? ~in_b : in_b, where in_sub_eff = in_first ? in_sub : sub_q.
  - add_cin = in_first ? in_sub : carry_q.
- in_ready = !out_valid || out_ready (single output register, full throughput).
- Accept = in_valid && in_ready. On accept:
  - out_sum<=add_sum, out_valid<=1, out_last<=in_last.
  - carry_q<=add_cout.
  - If in_first: sub_q<=in_sub.
  - zero_acc<=(in_first?1:zero_acc) && (add_sum==0).
  - If in_last, also:
    - out_carry<=add_cout.
    - out_zero<= that same updated zero_acc value.
    - out_ovf<=carry_into_msb ^ add_cout, where carry_into_msb = add_a[W-1]^add_b[W-1]^add_sum[W-1].
    - zero_acc<=1 and carry_q<=0 afterwards.
- Latency: a limb accepted at cycle N gives its result at out_* from cycle N+1.
- If out_valid && !out_ready with no accept: out_* hold stable.
- Output handshake: on out_valid && out_ready with no simultaneous accept, out_valid<=0. A simultaneous accept and drain replaces the output register with no bubble.
- A single-limb operation has in_first=in_last=1.
- An in_first limb always restarts carry and sign chaining, even if the previous operation lacked in_last. The old partial chain is discarded; already-emitted limbs are not retracted.
- in_valid with in_ready=0: the adder inputs still follow the port and nothing is captured. The upstream source must hold its data.
- rst_n assertion mid-operation aborts it. The first limb after reset must carry in_first=1; a non-first limb after reset uses carry_q=0.
- out_carry/out_ovf/out_zero hold their last value while out_last=0; the consumer ignores them.

Test Plan:
- Single-limb add: A=0xFFFF_FFFF_FFFF_FFFF, B=1, first=last=1 -> out_sum=0, out_carry=1, out_zero=1, out_ovf=0, out_valid exactly 1 cycle after accept.
- Two-limb add 128-bit: A={0,0xFFFF..FF}, B={0,1} -> limb0 sum=0, limb1 sum=1 with out_last=1, out_carry=0, out_zero=0.
- Single-limb sub: A=5, B=7, in_sub=1 -> out_sum=0xFFFF_FFFF_FFFF_FFFE, out_carry=0 (borrow), out_ovf=0. Also A=0x8000_0000_0000_0000, B=1, sub -> out_sum=0x7FFF_FFFF_FFFF_FFFF, out_ovf=1.
- Backpressure: out_ready=0 for 3 cycles with a 3-limb op streaming -> in_ready drops after the first accept, out_sum stable, no limb lost or duplicated. out_ready=1 then gives back-to-back limbs at 1 per cycle and correct carry chain.
- Restart: a limb with in_first=1 arrives after a non-last limb whose cout was 1 -> new op uses cin=in_sub, not the stale carry.
- Async reset mid-operation: assert rst_n=0 between limbs 1 and 2 -> out_valid=0 immediately, carry_q=0. A new op after release computes correctly.
